// File: rtl/weight_bram_loader.sv
// Streams signed weight words into NUM_BRAMS banks, one bank per word, row by row.
// Each accepted word becomes a registered one-hot write one cycle later.
module weight_bram_loader #(
    parameter int DW         = 16,
    parameter int NUM_BRAMS  = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [ADDR_WIDTH:0]                num_rows,
    input  logic                               s_valid,
    input  logic signed [DW-1:0]               s_data,
    output logic                               s_ready,
    output logic [NUM_BRAMS-1:0]               w_we,
    output logic [NUM_BRAMS*ADDR_WIDTH-1:0]    w_addr_wr_flat,
    output logic signed [NUM_BRAMS*DW-1:0]     w_din_flat,
    output logic                               busy,
    output logic                               done
);

    localparam int BANK_W = (NUM_BRAMS > 1) ? $clog2(NUM_BRAMS) : 1;
    localparam int ROW_W  = ADDR_WIDTH + 1;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BRAMS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [BANK_W-1:0]       bank_idx_q;
    logic [ROW_W-1:0]        row_cnt_q;
    logic [ROW_W-1:0]        rows_q;
    logic [ADDR_WIDTH-1:0]   base_q;

    logic                    accept;
    logic                    last_word;
    logic                    start_ok;
    logic [ADDR_WIDTH-1:0]   row_addr;

    assign s_ready   = (state_q == LOAD);
    assign busy      = (state_q == LOAD);
    // The DONE state lines up with the registered write of the final word.
    assign done      = (state_q == DONE);

    assign accept    = s_valid && s_ready;
    assign start_ok  = (state_q == IDLE) && start;
    assign last_word = (bank_idx_q == LAST_BANK) && (row_cnt_q == rows_q - ROW_W'(1));
    // Truncation to ADDR_WIDTH gives the modulo wrap past the top of the bank.
    assign row_addr  = base_q + row_cnt_q[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_rows == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && last_word) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            rows_q     <= '0;
            bank_idx_q <= '0;
            row_cnt_q  <= '0;
        end else if (start_ok) begin
            base_q     <= base_addr;
            rows_q     <= num_rows;
            bank_idx_q <= '0;
            row_cnt_q  <= '0;
        end else if (accept) begin
            if (bank_idx_q == LAST_BANK) begin
                bank_idx_q <= '0;
                row_cnt_q  <= row_cnt_q + ROW_W'(1);
            end else begin
                bank_idx_q <= bank_idx_q + BANK_W'(1);
            end
        end
    end

    // Address and data hold between writes; only the enable drops back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_we           <= '0;
            w_addr_wr_flat <= '0;
            w_din_flat     <= '0;
        end else begin
            w_we <= accept ? (NUM_BRAMS'(1) << bank_idx_q) : '0;
            if (accept) begin
                w_addr_wr_flat <= {NUM_BRAMS{row_addr}};
                w_din_flat     <= {NUM_BRAMS{s_data}};
            end
        end
    end

endmodule

// File: tb/tb_weight_bram_loader.sv
// Scoreboarded bench for weight_bram_loader: the driver predicts each write from the
// word index alone, a negedge monitor pops and compares every write the DUT issues.
module tb_weight_bram_loader;

    localparam int DW = 16;
    localparam int N  = 16;
    localparam int AW = 11;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  abort;
    logic [AW-1:0]         base_addr;
    logic [AW:0]           num_rows;
    logic                  s_valid;
    logic signed [DW-1:0]  s_data;
    logic                  s_ready;
    logic [N-1:0]          w_we;
    logic [N*AW-1:0]       w_addr_wr_flat;
    logic signed [N*DW-1:0] w_din_flat;
    logic                  busy;
    logic                  done;

    weight_bram_loader #(.DW(DW), .NUM_BRAMS(N), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .num_rows(num_rows),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .w_we(w_we), .w_addr_wr_flat(w_addr_wr_flat), .w_din_flat(w_din_flat),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    bit   bare_done_ok = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (w_we != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 256'(w_we), 256'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("we",   256'(w_we), 256'(e.we));
                    check("addr", 256'(w_addr_wr_flat), 256'({N{e.addr}}));
                    check("data", 256'(w_din_flat), 256'({N{e.data}}));
                    check("done_with_write", 256'(done), 256'(e.last));
                end
            end else if (done) begin
                check("done_without_write", 256'(done), 256'(bare_done_ok));
            end
            if (done) done_cnt++;
        end
    end

    // bubble: 0 continuous, 1 every other cycle, 2 random
    task automatic run_load(input logic [AW-1:0] base, input int rows, input int bubble,
                            input int abort_after, input bit mid_start, input bit seq_data);
        logic [DW-1:0] d[$];
        int n_words, n_exp, k, cyc, done_before;
        bit acc;
        exp_t e;
        n_words = rows * N;
        n_exp   = (abort_after >= 0) ? abort_after : n_words;
        for (int i = 0; i < n_words; i++) d.push_back(seq_data ? DW'(i) : DW'($urandom));
        for (int i = 0; i < n_exp; i++) begin
            e.we   = N'(1) << (i % N);
            e.addr = AW'((int'(base) + i / N) % (1 << AW));
            e.data = d[i];
            e.last = (abort_after < 0) && (i == n_words - 1);
            sb.push_back(e);
        end
        done_before = done_cnt;

        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_rows = (AW+1)'(rows);
        @(posedge clk); #1;
        start = 1'b0; base_addr = AW'($urandom); num_rows = (AW+1)'($urandom);
        check("busy_after_start", 256'(busy), 256'(1));
        check("ready_after_start", 256'(s_ready), 256'(1));

        k = 0; cyc = 0;
        while (k < n_exp && cyc < 2000) begin
            case (bubble)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 2 == 0);
                default: s_valid = 1'($urandom);
            endcase
            s_data = d[k];
            abort  = (abort_after >= 0) && (k == n_exp - 1) && s_valid;
            start  = mid_start && (cyc == 3);
            acc    = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
        end
        if (cyc >= 2000) check("load_timeout", 256'(k), 256'(n_exp));
        s_valid = 1'b0; abort = 1'b0; start = 1'b0;
        check("ready_after_last", 256'(s_ready), 256'(0));
        if (abort_after >= 0) check("busy_after_abort", 256'(busy), 256'(0));

        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", 256'(busy), 256'(0));
        check("idle_ready", 256'(s_ready), 256'(0));
        check("sb_drained", 256'(sb.size()), 256'(0));
        check("done_pulses", 256'(done_cnt - done_before), 256'((abort_after >= 0) ? 0 : 1));
    endtask

    // Zero rows: the start-sampling edge moves straight to DONE, so done shows in the
    // cycle after the start cycle (the second cycle counting the start cycle) with no write.
    task automatic zero_rows();
        int done_before;
        done_before  = done_cnt;
        bare_done_ok = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; num_rows = '0; base_addr = AW'($urandom);
        check("zero_done_before", 256'(done), 256'(0));
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_done", 256'(done), 256'(1));
        check("zero_we", 256'(w_we), 256'(0));
        check("zero_ready", 256'(s_ready), 256'(0));
        @(posedge clk); #1;
        check("zero_done_end", 256'(done), 256'(0));
        check("zero_ready_end", 256'(s_ready), 256'(0));
        @(negedge clk); #1;
        bare_done_ok = 1'b0;
        check("zero_done_pulses", 256'(done_cnt - done_before), 256'(1));
    endtask

    task automatic reset_mid_load();
        exp_t e;
        logic [AW-1:0] base;
        base = AW'($urandom);
        // Seven words are accepted; the seventh write is cut off by reset before the monitor samples it.
        for (int i = 0; i < 6; i++) begin
            e.we = N'(1) << i; e.addr = base; e.data = DW'(16'h1000 + i); e.last = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_rows = (AW+1)'(2);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1; s_data = DW'(16'h1000 + i);
            @(posedge clk); #1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_ready", 256'(s_ready), 256'(0));
        check("rst_we",    256'(w_we), 256'(0));
        check("rst_addr",  256'(w_addr_wr_flat), 256'(0));
        check("rst_din",   256'(w_din_flat), 256'(0));
        check("rst_busy",  256'(busy), 256'(0));
        check("rst_done",  256'(done), 256'(0));
        check("rst_sb",    256'(sb.size()), 256'(0));
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        // Stream stays valid after release: no write may occur without a new start.
        s_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("post_rst_busy",  256'(busy), 256'(0));
        check("post_rst_ready", 256'(s_ready), 256'(0));
        check("post_rst_we",    256'(w_we), 256'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; num_rows = '0;
        s_valid = 1'b0; s_data = '0;
        #1;
        check("init_ready", 256'(s_ready), 256'(0));
        check("init_we",    256'(w_we), 256'(0));
        check("init_busy",  256'(busy), 256'(0));
        check("init_done",  256'(done), 256'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        run_load(AW'(0), 2, 0, -1, 1'b0, 1'b1);     // continuous, data 0..31
        run_load(AW'(0), 2, 1, -1, 1'b0, 1'b1);     // bubble every other cycle
        run_load(AW'(2047), 2, 0, -1, 1'b0, 1'b0);  // address wrap
        zero_rows();
        run_load(AW'($urandom), 3, 0, 5, 1'b1, 1'b0); // mid-load start ignored, abort after 5
        reset_mid_load();
        for (int i = 0; i < 6; i++) begin
            run_load(AW'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                     -1, 1'(i % 2), 1'b0);
        end
        run_load(AW'($urandom), 2, 2, int'($urandom_range(1, 30)), 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
